// File: rtl/sram_like_responder.sv
// sram_like_responder: responder end of an sram-like req/addr_ok/data_ok bus.
// Requests are accepted into an in-order circular queue, answered a fixed LAT
// cycles later at the earliest, and backed by an internal word RAM that is not
// cleared by reset.
//
// Handshake: a request transfers in any cycle where req && addr_ok (addr_ok is
// a combinational function of req and the current outstanding count and never
// waits on a same-cycle pop). Responses have no ready: data_ok is a one-cycle
// pulse for the oldest outstanding request and the initiator must take it.
module sram_like_responder #(
  parameter int AW    = 10,
  parameter int DEPTH = 4,
  parameter int LAT   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req,
  input  logic                     wr,
  input  logic [2:0]               size,
  input  logic [31:0]              addr,
  input  logic [3:0]               wstrb,
  input  logic [31:0]              wdata,
  output logic                     addr_ok,
  output logic                     data_ok,
  output logic [31:0]              rdata,
  output logic [$clog2(DEPTH):0]   outstanding
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  // Word RAM (no reset: contents survive reset)
  logic [31:0]   r_mem [0:(1<<AW)-1];

  // Response queue: stored data and per-slot countdown to eligibility
  logic [31:0]   r_q_data [DEPTH];
  logic [CW-1:0] r_q_cd   [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [OW-1:0] r_count;
  logic [31:0]   r_rdata_hold;

  logic [AW-1:0] w_idx;
  logic          w_accept;
  logic          w_pop;
  logic          w_head_ready;
  logic [31:0]   w_rd_word;
  logic          w_unused;

  // size is informational and the address bits outside the word index are ignored
  assign w_unused = ^{size, addr[31:AW+2], addr[1:0]};

  assign w_idx     = addr[AW+1:2];
  assign w_rd_word = r_mem[w_idx];

  // Handshake and response decode, all from registered state plus req
  always_comb begin
    w_head_ready = 1'b0;
    w_pop        = 1'b0;
    addr_ok      = 1'b0;
    w_accept     = 1'b0;
    data_ok      = 1'b0;
    rdata        = r_rdata_hold;
    w_head_ready = (r_count != '0) && (r_q_cd[r_rd_ptr] == '0);
    w_pop        = !reset && w_head_ready;
    addr_ok      = req && !reset && (r_count < OW'(DEPTH));
    w_accept     = addr_ok;
    data_ok      = w_pop;
    if (w_pop) begin
      rdata = r_q_data[r_rd_ptr];
    end
  end

  assign outstanding = r_count;

  // Byte-strobed RAM write at the accept edge
  always_ff @(posedge clk) begin
    if (w_accept && wr) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) begin
          r_mem[w_idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  // Queue payload: countdowns saturate at 0; a newly accepted entry loads LAT-1
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (r_q_cd[i] != '0) begin
        r_q_cd[i] <= r_q_cd[i] - CW'(1);
      end
    end
    if (w_accept) begin
      r_q_data[r_wr_ptr] <= wr ? 32'h0 : w_rd_word;
      r_q_cd[r_wr_ptr]   <= CW'(LAT - 1);
    end
  end

  // Queue pointers, occupancy and held read data
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_rdata_hold <= 32'h0;
    end else begin
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr     <= r_rd_ptr + PW'(1);
        r_rdata_hold <= r_q_data[r_rd_ptr];
      end
      unique case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + OW'(1);
        2'b01:   r_count <= r_count - OW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_like_responder.sv
// Bench for sram_like_responder (AW=10, DEPTH=4, LAT=8): directed bus scenarios
// followed by randomized traffic, scored against a word-array memory model and
// an in-order response-time model.
module tb_sram_like_responder;

  localparam int AW    = 10;
  localparam int DEPTH = 4;
  localparam int LAT   = 8;
  localparam int MEMW  = 1 << AW;
  localparam int EW    = 65;   // {is_wr, data[31:0], resp_cycle[31:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req;
  logic        wr;
  logic [2:0]  size;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic [$clog2(DEPTH):0] outstanding;

  sram_like_responder #(.AW(AW), .DEPTH(DEPTH), .LAT(LAT)) dut (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .addr(addr),
    .wstrb(wstrb), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok),
    .rdata(rdata), .outstanding(outstanding)
  );

  int cyc = 0;
  always begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  logic [31:0]   mem_m [MEMW];
  int            checks = 0;
  int            failures = 0;
  int            n_start = 0;
  int            last_resp = -100;
  logic [31:0]   hold_last = 32'h0;
  bit            hold_known = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s at cycle %0d: got 0x%08h expected 0x%08h", nm, cyc, act, expv);
    end
  endtask

  // Accept tracker: on every accepted request, update the model memory and
  // push the expected response with its predicted response cycle.
  always begin
    logic [31:0] d;
    int idx;
    int rc;
    @(negedge clk);
    #1;
    if (reset) begin
      chk("addr_ok_in_reset", {31'b0, addr_ok}, 32'h0);
      last_resp = -100;
    end else begin
      chk("addr_ok", {31'b0, addr_ok}, {31'b0, (req && (n_start < DEPTH))});
      if (req && addr_ok) begin
        idx = int'((addr >> 2) % MEMW);
        d = 32'h0;
        if (wr) begin
          for (int b = 0; b < 4; b++)
            if (wstrb[b]) mem_m[idx][8*b +: 8] = wdata[8*b +: 8];
        end else begin
          d = mem_m[idx];
        end
        rc = (cyc + LAT > last_resp + 1) ? cyc + LAT : last_resp + 1;
        last_resp = rc;
        exp_q.push_back({wr, d, 32'(rc)});
      end
    end
  end

  // Response monitor: pops and compares whenever data_ok is seen, and flags
  // responses that are missing, unexpected or mistimed.
  always begin
    logic [EW-1:0] e;
    @(negedge clk);
    n_start = exp_q.size();
    if (reset) begin
      chk("data_ok_in_reset", {31'b0, data_ok}, 32'h0);
      exp_q.delete();
      hold_last  = 32'h0;
      hold_known = 1'b1;
    end else begin
      chk("outstanding", 32'(outstanding), 32'(n_start));
      if (data_ok) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_data_ok at cycle %0d: got data_ok=1 expected none", cyc);
        end else begin
          e = exp_q.pop_front();
          chk("resp_cycle", 32'(cyc), e[31:0]);
          if (!e[64]) begin
            chk("rdata", rdata, e[63:32]);
            hold_last  = e[63:32];
            hold_known = 1'b1;
          end else begin
            hold_known = 1'b0;
          end
        end
      end else begin
        if (hold_known) chk("rdata_hold", rdata, hold_last);
        if (exp_q.size() > 0 && int'(exp_q[0][31:0]) <= cyc) begin
          e = exp_q.pop_front();
          checks++;
          failures++;
          $display("FAIL missing_data_ok at cycle %0d: got data_ok=0 expected 1", cyc);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a posedge; returns just after a posedge, with the
  // acceptance cycle (or -1 if never accepted within the budget).
  task automatic issue(input bit w, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] d, output int acc);
    acc   = -1;
    req   = 1'b1;
    wr    = w;
    addr  = a;
    wstrb = s;
    wdata = d;
    size  = 3'(2);
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      #2;
      if (addr_ok) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout at cycle %0d: got no addr_ok expected accept", cyc);
    end
    @(posedge clk);
    #1;
    req = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout at cycle %0d: got %0d pending expected 0", cyc, exp_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog at cycle %0d: got no finish expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int a0, a1;
    int acc [5];
    logic [31:0] ra;
    reset = 1'b1; req = 1'b0; wr = 1'b0; size = '0;
    addr = '0; wstrb = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // full-word write then read back
    issue(1'b1, 32'h10, 4'hF, 32'h12345678, a0);
    issue(1'b0, 32'h10, 4'h0, 32'h0, a1);
    drain();

    // single-byte strobe merge
    issue(1'b1, 32'h10, 4'b0010, 32'h0000AB00, a0);
    issue(1'b0, 32'h10, 4'h0, 32'h0, a1);
    drain();

    // write then read same word on consecutive cycles
    issue(1'b1, 32'h20, 4'hF, 32'hDEADBEEF, a0);
    issue(1'b0, 32'h20, 4'h0, 32'h0, a1);
    chk("raw_accept_gap", 32'(a1 - a0), 32'd1);
    drain();

    // req held across a full queue
    for (int i = 0; i < 5; i++) issue(1'b0, (i % 2) ? 32'h20 : 32'h10, 4'h0, 32'h0, acc[i]);
    for (int i = 1; i < 4; i++) chk("full_accept_gap", 32'(acc[i] - acc[0]), 32'(i));
    chk("full_fifth_accept", 32'(acc[4] - acc[0]), 32'(LAT + 1));
    drain();

    // reset with two reads in flight drops them; RAM survives
    issue(1'b0, 32'h10, 4'h0, 32'h0, a0);
    issue(1'b0, 32'h20, 4'h0, 32'h0, a1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (LAT + 4) @(posedge clk);
    #1;
    issue(1'b0, 32'h10, 4'h0, 32'h0, a0);
    drain();

    // address aliasing above the word-index bits
    issue(1'b1, 32'h1010, 4'hF, 32'h55AA55AA, a0);
    issue(1'b0, 32'h0010, 4'h0, 32'h0, a1);
    drain();

    // fill a 16-word working region, then random traffic over it
    for (int w = 0; w < 16; w++) issue(1'b1, 32'(w << 2), 4'hF, $urandom, a0);
    for (int n = 0; n < 300; n++) begin
      ra = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 15) << 2) | 32'($urandom_range(0, 3));
      issue(1'($urandom_range(0, 1)), ra, 4'($urandom_range(0, 15)), $urandom, a0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
